pipe_ctrl: RTL and testbench

- Parametrised pipeline control unit for the mycpu core; generalises the single shared stall signal.
- Collects per-stage stall requests, exception requests and branch redirects.
- Produces per-stage stall, bubble and flush vectors plus a single PC redirect.
- Contains the exception-flush state machine, a stall watchdog and a stall-cycle performance counter.
- Sits beside the IF/ID/EX/MEM/WB stages at core top level.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_stall_prio_enc.sv | 34 +++
 rtl/pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared encodings for the pipeline controller (FSM states, stage indices, bus width).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Controller states: RUN is normal flow, WAIT holds an exception behind a
    // later-stage stall, FLUSH is the single redirect/clear cycle.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Default pipeline register positions.
    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    // Default width of the per-stage control buses.
    localparam int STALL_WD  = 6;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Purpose: turn per-stage stall requests into stall/bubble vectors (highest requester wins).
// Latency: purely combinational, same cycle.
// Backpressure: a request at stage k holds every stage 0..k and injects a NOP at k+1.
module stall_prio_enc #(
    parameter int NSTAGE = 6
) (
    input  logic [NSTAGE-1:0] i_stallreq,
    output logic [NSTAGE-1:0] o_stall,
    output logic [NSTAGE-1:0] o_bubble
);

    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_bubble;
    logic              w_acc;

    // Stage j holds when any stage at or above j requests a stall; the first
    // non-holding stage above the held block receives the bubble.
    always_comb begin
        w_stall  = '0;
        w_bubble = '0;
        w_acc    = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            w_acc      = w_acc | i_stallreq[i];
            w_stall[i] = w_acc;
        end
        for (int j = 1; j < NSTAGE; j++) begin
            w_bubble[j] = w_stall[j-1] & ~w_stall[j];
        end
    end

    assign o_stall  = w_stall;
    assign o_bubble = w_bubble;

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline control - per-stage stall/bubble/flush, PC redirect, exception FSM, watchdog, stall counter.
// Latency: stall/bubble/branch redirect combinational; exception redirect one cycle after acceptance.
// Backpressure: exceptions wait in WAIT while any stage beyond the commit stage stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE     = STALL_WD,
    parameter int PC_W       = 32,
    parameter int BR_STAGE   = STAGE_ID,
    parameter int EXCP_STAGE = STAGE_MEM,
    parameter int DELAY_SLOT = 1,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              excp_valid,
    input  logic [PC_W-1:0]   excp_vector,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              busy_flush,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    localparam logic [NSTAGE-1:0] ONES   = {NSTAGE{1'b1}};
    localparam logic [NSTAGE-1:0] ONE    = {{(NSTAGE-1){1'b0}}, 1'b1};
    // Stages 0..EXCP_STAGE-1: held while the excepting instruction is squashed.
    localparam logic [NSTAGE-1:0] M_EXCP_LO  = ONES >> (NSTAGE - EXCP_STAGE);
    // Stages 0..EXCP_STAGE: cleared during the flush cycle.
    localparam logic [NSTAGE-1:0] M_EXCP_FL  = ONES >> (NSTAGE - EXCP_STAGE - 1);
    // The register just past the commit stage gets a NOP instead of the faulting op.
    localparam logic [NSTAGE-1:0] M_EXCP_BUB = ONE << (EXCP_STAGE + 1);
    // Stages 1..BR_STAGE-1: wrong-path instructions when there is no delay slot.
    localparam logic [NSTAGE-1:0] M_BR_FL    = (ONES >> (NSTAGE - BR_STAGE)) & ~ONE;

    state_t            r_state;
    logic [PC_W-1:0]   r_pend_pc;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_stall_timeout;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic [NSTAGE-1:0] w_pstall;
    logic [NSTAGE-1:0] w_pbubble;
    logic              w_later_stall;
    logic              w_accept;
    logic              w_to_wait;
    logic [NSTAGE-1:0] w_stall_c;
    logic [NSTAGE-1:0] w_bubble_c;
    logic [NSTAGE-1:0] w_flush_c;
    logic              w_rv_c;
    logic [PC_W-1:0]   w_rpc_c;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_bubble;
    logic [NSTAGE-1:0] w_flush;
    logic [NSTAGE-1:0] w_live;

    stall_prio_enc #(
        .NSTAGE (NSTAGE)
    ) u_prio (
        .i_stallreq (stallreq),
        .o_stall    (w_pstall),
        .o_bubble   (w_pbubble)
    );

    // Any stall beyond the commit stage blocks exception acceptance.
    assign w_later_stall = |(stallreq & ~M_EXCP_FL);

    // Per-state control vectors and redirect selection.
    always_comb begin
        w_stall_c  = w_pstall;
        w_bubble_c = w_pbubble;
        w_flush_c  = '0;
        w_rv_c     = 1'b0;
        w_rpc_c    = '0;
        w_accept   = 1'b0;
        w_to_wait  = 1'b0;
        case (r_state)
            RUN: begin
                if (excp_valid) begin
                    // Exception wins over any same-cycle branch.
                    if (w_later_stall) w_to_wait = 1'b1;
                    else               w_accept  = 1'b1;
                end else if (br_taken && !w_pstall[BR_STAGE]) begin
                    w_rv_c  = 1'b1;
                    w_rpc_c = br_target;
                    if (DELAY_SLOT == 0) w_flush_c = M_BR_FL;
                end
            end
            WAIT: begin
                w_stall_c = w_pstall | M_EXCP_FL;
                if (!w_later_stall) w_accept = 1'b1;
            end
            FLUSH: begin
                w_stall_c  = '0;
                w_bubble_c = '0;
                w_flush_c  = M_EXCP_FL;
                w_rv_c     = 1'b1;
                w_rpc_c    = r_pend_pc;
            end
            default: begin
                w_stall_c  = w_pstall;
                w_bubble_c = w_pbubble;
            end
        endcase
        if (w_accept) begin
            w_stall_c  = w_pstall | M_EXCP_LO;
            w_bubble_c = (w_pbubble | M_EXCP_BUB) & ~w_stall_c;
        end
    end

    // Flush outranks stall/bubble; everything is forced low while reset is held.
    assign w_live   = {NSTAGE{rst}};
    assign w_flush  = w_flush_c & w_live;
    assign w_stall  = w_stall_c & ~w_flush_c & w_live;
    assign w_bubble = w_bubble_c & ~w_flush_c & w_live;

    assign stall          = w_stall;
    assign bubble         = w_bubble;
    assign flush          = w_flush;
    assign redirect_valid = w_rv_c & rst;
    assign redirect_pc    = rst ? w_rpc_c : '0;
    assign busy_flush     = (r_state != RUN);
    assign stall_timeout  = r_stall_timeout;
    assign stall_cycles   = r_stall_cycles;

    // Exception FSM: capture the handler PC, wait out later stalls, then flush once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_pend_pc <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (excp_valid) begin
                        r_pend_pc <= excp_vector;
                        r_state   <= w_to_wait ? WAIT : FLUSH;
                    end
                end
                WAIT: begin
                    if (w_accept) r_state <= FLUSH;
                end
                FLUSH:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // Watchdog: saturating run-length of stall[0]; sticky flag once it hits TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt        <= '0;
            r_stall_timeout <= 1'b0;
        end else if (w_stall[0]) begin
            if (r_wd_cnt != WD_MAX) r_wd_cnt <= r_wd_cnt + WD_W'(1);
            if (r_wd_cnt >= WD_MAX - WD_W'(1)) r_stall_timeout <= 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // Performance counter: total cycles with the PC held, wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall[0]) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: directed self-checking bench for pipe_ctrl (DELAY_SLOT=0, TIMEOUT=8).
// Latency: checks combinational outputs 2ns after each rising edge.
// Backpressure: stall paths exercised through stallreq patterns.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic        br_taken;
    logic [31:0] br_target;
    logic        excp_valid;
    logic [31:0] excp_vector;
    logic [5:0]  stall;
    logic [5:0]  bubble;
    logic [5:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy_flush;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int n_chk;
    int n_pass;

    pipe_ctrl #(
        .NSTAGE     (6),
        .PC_W       (32),
        .BR_STAGE   (2),
        .EXCP_STAGE (4),
        .DELAY_SLOT (0),
        .TIMEOUT    (8),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq       (stallreq),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .excp_valid     (excp_valid),
        .excp_vector    (excp_vector),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy_flush     (busy_flush),
        .stall_timeout  (stall_timeout),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b0;
        stallreq    = '0;
        br_taken    = 1'b0;
        br_target   = '0;
        excp_valid  = 1'b0;
        excp_vector = '0;
        #3;
        chk("rst_stall",   stall, 0);
        chk("rst_bubble",  bubble, 0);
        chk("rst_flush",   flush, 0);
        chk("rst_rv",      redirect_valid, 0);
        chk("rst_rpc",     redirect_pc, 0);
        chk("rst_busy",    busy_flush, 0);
        chk("rst_tmo",     stall_timeout, 0);
        chk("rst_cycles",  stall_cycles, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // EX stall: hold 0..3, bubble into MEM
        stallreq = 6'b001000; #1;
        chk("ex_stall",  stall, 6'b001111);
        chk("ex_bubble", bubble, 6'b010000);
        chk("ex_flush",  flush, 0);
        tick(); tick(); tick();
        stallreq = '0; #1;
        chk("ex_cycles3", stall_cycles, 3);
        tick(); #1;
        chk("idle_cycles", stall_cycles, 3);

        // Branch, no stall: same-cycle redirect and IF flush
        br_taken = 1'b1; br_target = 32'hBFC00100; #1;
        chk("br_rv",    redirect_valid, 1);
        chk("br_rpc",   redirect_pc, 32'hBFC00100);
        chk("br_flush", flush, 6'b000010);
        chk("br_stall", stall, 0);
        // Branch with IF stalling: flush on IF beats its stall
        stallreq = 6'b000010; #1;
        chk("brif_stall",  stall, 6'b000001);
        chk("brif_bubble", bubble, 6'b000100);
        chk("brif_flush",  flush, 6'b000010);
        chk("brif_rv",     redirect_valid, 1);
        tick();
        // Branch while BR stage stalls: ignored
        stallreq = 6'b000100; #1;
        chk("brst_rv",     redirect_valid, 0);
        chk("brst_flush",  flush, 0);
        chk("brst_stall",  stall, 6'b000111);
        chk("brst_bubble", bubble, 6'b001000);
        tick();
        br_taken = 1'b0; stallreq = '0;

        // Exception, no stalls
        excp_valid = 1'b1; excp_vector = 32'hBFC00380; #1;
        chk("ex0_stall",  stall, 6'b001111);
        chk("ex0_bubble", bubble, 6'b100000);
        chk("ex0_rv",     redirect_valid, 0);
        chk("ex0_busy",   busy_flush, 0);
        tick();
        excp_valid = 1'b0; #1;
        chk("ex1_busy",  busy_flush, 1);
        chk("ex1_flush", flush, 6'b011111);
        chk("ex1_rv",    redirect_valid, 1);
        chk("ex1_rpc",   redirect_pc, 32'hBFC00380);
        chk("ex1_stall", stall, 0);
        tick(); #1;
        chk("ex2_busy",  busy_flush, 0);
        chk("ex2_rv",    redirect_valid, 0);

        // Exception behind a WB stall held 3 cycles
        stallreq = 6'b100000; excp_valid = 1'b1; #1;
        chk("w0_stall", stall, 6'b111111);
        chk("w0_busy",  busy_flush, 0);
        tick();
        excp_valid = 1'b0; br_taken = 1'b1; br_target = 32'h00001000; #1;
        chk("w1_busy",  busy_flush, 1);
        chk("w1_rv",    redirect_valid, 0);
        chk("w1_stall", stall, 6'b111111);
        tick(); #1;
        chk("w2_busy",  busy_flush, 1);
        chk("w2_rv",    redirect_valid, 0);
        tick();
        stallreq = '0; br_taken = 1'b0; #1;
        chk("wacc_busy",   busy_flush, 1);
        chk("wacc_stall",  stall, 6'b001111);
        chk("wacc_bubble", bubble, 6'b100000);
        chk("wacc_rv",     redirect_valid, 0);
        tick(); #1;
        chk("wfl_flush", flush, 6'b011111);
        chk("wfl_rv",    redirect_valid, 1);
        chk("wfl_rpc",   redirect_pc, 32'hBFC00380);
        chk("wfl_busy",  busy_flush, 1);
        tick(); #1;
        chk("wrun_busy",  busy_flush, 0);
        chk("wrun_cycles", stall_cycles, 10);

        // Exception and branch together: exception only
        excp_valid = 1'b1; excp_vector = 32'h80000180;
        br_taken = 1'b1; br_target = 32'h12345678; #1;
        chk("eb_rv",    redirect_valid, 0);
        chk("eb_stall", stall, 6'b001111);
        tick();
        excp_valid = 1'b0; br_taken = 1'b0; #1;
        chk("eb_rv1",  redirect_valid, 1);
        chk("eb_rpc1", redirect_pc, 32'h80000180);
        tick();

        // Watchdog: fires on the 8th consecutive stalled cycle, sticky
        stallreq = 6'b001000;
        repeat (7) tick();
        #1;
        chk("wd7_tmo", stall_timeout, 0);
        tick(); #1;
        chk("wd8_tmo", stall_timeout, 1);
        stallreq = '0;
        tick(); tick(); #1;
        chk("wd_sticky", stall_timeout, 1);
        chk("wd_cycles", stall_cycles, 19);

        // Asynchronous reset with a stall request present
        stallreq = 6'b001000; #1;
        rst = 1'b0; #1;
        chk("ar_stall",  stall, 0);
        chk("ar_bubble", bubble, 0);
        chk("ar_tmo",    stall_timeout, 0);
        chk("ar_cycles", stall_cycles, 0);
        stallreq = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset in the middle of FLUSH: no redirect afterwards
        excp_valid = 1'b1; excp_vector = 32'hBFC00380;
        tick();
        excp_valid = 1'b0; #1;
        chk("mf_busy", busy_flush, 1);
        chk("mf_rv",   redirect_valid, 1);
        rst = 1'b0; #1;
        chk("mf_rst_rv",    redirect_valid, 0);
        chk("mf_rst_busy",  busy_flush, 0);
        chk("mf_rst_flush", flush, 0);
        chk("mf_rst_rpc",   redirect_pc, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(); #1;
        chk("mf_after_rv",   redirect_valid, 0);
        chk("mf_after_busy", busy_flush, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
